// File: rtl/img_proc_pkg.sv
// Shared types, Sobel coefficients and saturation helpers for the greyscale/Sobel pipeline.
package img_proc_pkg;

    typedef enum logic [1:0] {
        MODE_GREY = 2'd0,
        MODE_VERT = 2'd1,
        MODE_HORZ = 2'd2,
        MODE_MAG  = 2'd3
    } mode_e;

    // Row 0 is the oldest line, column 0 the oldest column of the window.
    localparam int KERN_GX [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
    localparam int KERN_GY [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

    function automatic int unsigned abs_int(input int v);
        return (v < 0) ? unsigned'(-v) : unsigned'(v);
    endfunction

    function automatic int unsigned sat_abs(input int v, input int unsigned max_val);
        int unsigned a;
        a = abs_int(v);
        return (a > max_val) ? max_val : a;
    endfunction

endpackage

// File: rtl/img_line_buf.sv
// Column-wise shift line buffer: dout is the sample pushed DEPTH enables ago.
module img_line_buf #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 320
) (
    input  logic              clk,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: storage arrays get no reset; stale contents are always masked downstream.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/img_proc_pipe.sv
// Bayer 2x2 greyscale decimation followed by a mode-selected 3x3 Sobel stage.
module img_proc_pipe
    import img_proc_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int IMG_W  = 640,
    parameter int ACC_W  = DATA_W + 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fval,
    input  logic              dval,
    input  logic [DATA_W-1:0] tap0,
    input  logic [DATA_W-1:0] tap1,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] pix_out,
    output logic              pix_valid,
    output logic [1:0]        mode_act
);

    localparam int GS_W  = IMG_W / 2;
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = 16;
    localparam int SUM_W = DATA_W + 2;
    localparam int unsigned PIX_MAX = (32'd1 << DATA_W) - 32'd1;

    logic              armed;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [DATA_W-1:0] prev_tap0, prev_tap1;
    logic [DATA_W-1:0] gs;
    logic              gs_valid, gs_border;
    logic              take, blk_done, at_border;
    logic [SUM_W-1:0]  blk_sum;
    logic [DATA_W-1:0] lb0_out, lb1_out;

    // Counting only starts after a genuine fval rise, so a reset mid-frame stays silent.
    assign take      = fval && armed && dval;
    assign blk_done  = take && col[0] && row[0];
    assign at_border = (row[ROW_W-1:1] < (ROW_W-1)'(2)) || (col[COL_W-1:1] < (COL_W-1)'(2));
    assign blk_sum   = SUM_W'(tap0) + SUM_W'(tap1) + SUM_W'(prev_tap0) + SUM_W'(prev_tap1);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed    <= 1'b0;
            col      <= '0;
            row      <= '0;
            mode_act <= '0;
        end else begin
            armed <= armed | ~fval;
            if (!fval) begin
                col      <= '0;
                row      <= '0;
                mode_act <= mode;
            end else if (take) begin
                if (col == COL_W'(IMG_W - 1)) begin
                    col <= '0;
                    if (row != '1) row <= row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_tap0 <= '0;
            prev_tap1 <= '0;
            gs        <= '0;
            gs_valid  <= 1'b0;
            gs_border <= 1'b0;
        end else begin
            gs_valid <= blk_done;
            if (dval) begin
                prev_tap0 <= tap0;
                prev_tap1 <= tap1;
            end
            if (blk_done) begin
                gs        <= DATA_W'(blk_sum >> 2);
                gs_border <= at_border;
            end
        end
    end

    img_line_buf #(.DATA_W(DATA_W), .DEPTH(GS_W)) u_lb0 (
        .clk(clk), .en(gs_valid), .din(gs), .dout(lb0_out)
    );

    img_line_buf #(.DATA_W(DATA_W), .DEPTH(GS_W)) u_lb1 (
        .clk(clk), .en(gs_valid), .din(lb0_out), .dout(lb1_out)
    );

    logic [DATA_W-1:0]       win     [3][3];
    logic [DATA_W-1:0]       win_nxt [3][3];
    logic signed [ACC_W-1:0] gx, gy;
    logic [DATA_W-1:0]       result;
    int                      acc_x, acc_y;

    // The kernel runs on the window as it will look after this shift, saving a cycle.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 2; c++) begin
                win_nxt[r][c] = win[r][c+1];
            end
        end
        win_nxt[0][2] = lb1_out;
        win_nxt[1][2] = lb0_out;
        win_nxt[2][2] = gs;
    end

    always_comb begin
        acc_x = 0;
        acc_y = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                acc_x += KERN_GX[r][c] * int'(win_nxt[r][c]);
                acc_y += KERN_GY[r][c] * int'(win_nxt[r][c]);
            end
        end
        gx = ACC_W'(acc_x);
        gy = ACC_W'(acc_y);
    end

    // NOTE: a default before the case keeps this block free of inferred latches.
    always_comb begin
        result = '0;
        unique case (mode_e'(mode_act))
            MODE_GREY: result = win_nxt[1][1];
            MODE_VERT: result = DATA_W'(sat_abs(int'(gy), PIX_MAX));
            MODE_HORZ: result = DATA_W'(sat_abs(int'(gx), PIX_MAX));
            MODE_MAG:  result = DATA_W'(sat_abs(int'(abs_int(int'(gx)) + abs_int(int'(gy))), PIX_MAX));
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_out   <= '0;
            pix_valid <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            pix_valid <= gs_valid;
            if (gs_valid) begin
                win     <= win_nxt;
                pix_out <= gs_border ? '0 : result;
            end
        end
    end

endmodule

// File: tb/tb_img_proc_pipe.sv
// Randomised bench for img_proc_pipe against a frame-level greyscale/Sobel model.
`timescale 1ns/1ps
module tb_img_proc_pipe;

    localparam int DATA_W = 12;
    localparam int IMG_W  = 8;
    localparam int GS_W   = IMG_W / 2;
    localparam int PMAX   = 4095;
    localparam int FRAME  = 8 * IMG_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fval = 1'b0, dval = 1'b0;
    logic [DATA_W-1:0] tap0 = '0, tap1 = '0;
    logic [1:0]        mode = '0;
    logic [DATA_W-1:0] pix_out;
    logic              pix_valid;
    logic [1:0]        mode_act;

    img_proc_pipe #(.DATA_W(DATA_W), .IMG_W(IMG_W), .ACC_W(DATA_W + 4)) dut (
        .clk(clk), .rst(rst), .fval(fval), .dval(dval), .tap0(tap0), .tap1(tap1),
        .mode(mode), .pix_out(pix_out), .pix_valid(pix_valid), .mode_act(mode_act)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int val; int due; } exp_t;

    int   n_tests = 0, n_fail = 0;
    exp_t expq[$];
    int   got[$];
    int   last_exp = 0;
    bit   armed = 1'b0;
    int   frame_mode = 0, mode_act_exp = 0;
    int   gimg [32][GS_W];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic int clamp(input int v);
        return (v > PMAX) ? PMAX : v;
    endfunction

    // Output for the greyscale pixel just completed at (gr,gc): centred on (gr-1,gc-1).
    function automatic int model_pix(input int gr, input int gc, input int m);
        int gx, gy;
        if (gr < 2 || gc < 2) return 0;
        if (m == 0) return gimg[gr-1][gc-1];
        gx = (gimg[gr-2][gc] - gimg[gr-2][gc-2]) + 2 * (gimg[gr-1][gc] - gimg[gr-1][gc-2])
           + (gimg[gr][gc] - gimg[gr][gc-2]);
        gy = (gimg[gr][gc-2] - gimg[gr-2][gc-2]) + 2 * (gimg[gr][gc-1] - gimg[gr-2][gc-1])
           + (gimg[gr][gc] - gimg[gr-2][gc]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        case (m)
            1:       return clamp(gy);
            2:       return clamp(gx);
            default: return clamp(gx + gy);
        endcase
    endfunction

    function automatic int got_at(input int i);
        return (i < got.size()) ? got[i] : -1;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            while (expq.size() > 0 && expq[0].due < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL output_missed: no pix_valid, expected value %0d due cycle %0d", expq[0].val, expq[0].due);
                void'(expq.pop_front());
            end
            if (expq.size() > 0 && expq[0].due == cyc) begin
                check("pix_valid", 32'(pix_valid), 1);
                check("pix_out", 32'(pix_out), expq[0].val);
                last_exp = expq[0].val;
                void'(expq.pop_front());
            end else begin
                check("idle_valid", 32'(pix_valid), 0);
                check("hold_pix_out", 32'(pix_out), last_exp);
            end
        end
        if (pix_valid) got.push_back(int'(pix_out));
    end

    task automatic drive(input bit f, input bit d, input int t0, input int t1);
        @(posedge clk);
        #1;
        fval = f;
        dval = d;
        tap0 = DATA_W'(t0);
        tap1 = DATA_W'(t1);
    endtask

    // pat: 0 flat 100, 1 taps 40/80, 2 horizontal edge, 3 vertical step, 4 random
    task automatic run_frame(input int pat, input int m, input int ndval, input int gap_max,
                             input int chg_at, input int rst_at);
        int   p0, p1, t0, t1, r, c, gr, gc;
        exp_t e;
        p0 = 0;
        p1 = 0;
        mode = 2'(m);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        armed = 1'b1;
        frame_mode = m;
        mode_act_exp = m;
        got.delete();
        for (int k = 0; k < ndval; k++) begin
            if (k == chg_at) mode = 2'((m + 1) % 4);
            if (k == rst_at) begin
                repeat (3) drive(1, 0, 0, 0);
                @(posedge clk);
                #1 rst = 1'b1;
                #1;
                check("rst_pix_valid", 32'(pix_valid), 0);
                check("rst_pix_out", 32'(pix_out), 0);
                check("rst_mode_act", 32'(mode_act), 0);
                expq.delete();
                last_exp = 0;
                armed = 1'b0;
                mode_act_exp = 0;
                @(posedge clk);
                #1 rst = 1'b0;
            end
            repeat ($urandom_range(0, gap_max)) drive(1, 0, 0, 0);
            r = k / IMG_W;
            c = k % IMG_W;
            case (pat)
                0:       begin t0 = 100; t1 = 100; end
                1:       begin t0 = 40;  t1 = 80;  end
                2:       begin t0 = ((r / 2) >= 2) ? 100 : 0;  t1 = t0; end
                3:       begin t0 = ((c / 2) >= 2) ? PMAX : 0; t1 = t0; end
                default: begin t0 = int'($urandom_range(0, PMAX)); t1 = int'($urandom_range(0, PMAX)); end
            endcase
            drive(1, 1, t0, t1);
            if (armed && (c % 2) == 1 && (r % 2) == 1) begin
                gr = r / 2;
                gc = c / 2;
                gimg[gr][gc] = (t0 + t1 + p0 + p1) >> 2;
                e.val = model_pix(gr, gc, frame_mode);
                e.due = cyc + 2;
                expq.push_back(e);
            end
            p0 = t0;
            p1 = t1;
        end
        check("mode_act_in_frame", 32'(mode_act), mode_act_exp);
        repeat (4) drive(0, 0, 0, 0);
        check("mode_act_between", 32'(mode_act), 32'(mode));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_pix_valid", 32'(pix_valid), 0);
        check("reset_pix_out", 32'(pix_out), 0);
        check("reset_mode_act", 32'(mode_act), 0);

        run_frame(0, 0, FRAME, 0, -1, -1);
        check("flat_count", got.size(), 16);
        check("flat_border", got_at(0), 0);
        check("flat_border_col", got_at(9), 0);
        check("flat_interior", got_at(10), 100);

        run_frame(1, 0, FRAME, 1, -1, -1);
        check("grey_40_80", got_at(15), 60);
        for (int m = 1; m < 4; m++) begin
            run_frame(1, m, FRAME, 1, -1, -1);
            check("flat_sobel_zero", got_at(10), 0);
        end

        run_frame(2, 1, FRAME, 0, -1, -1);
        check("hedge_vert", got_at(10), 400);
        check("hedge_vert_next", got_at(15), 400);
        run_frame(2, 2, FRAME, 0, -1, -1);
        check("hedge_horz", got_at(10), 0);

        run_frame(3, 3, FRAME, 0, -1, -1);
        check("vstep_sat", got_at(10), 4095);
        check("vstep_sat_next", got_at(11), 4095);

        run_frame(2, 0, FRAME, 0, 20, -1);
        check("midframe_mode_held", got_at(14), 100);
        run_frame(2, 1, FRAME, 0, -1, -1);
        check("next_frame_mode", got_at(14), 400);

        run_frame(3, 2, FRAME, 0, -1, 62);
        run_frame(0, 0, FRAME, 0, -1, -1);
        check("post_reset_count", got.size(), 16);
        check("post_reset_border", got_at(5), 0);
        check("post_reset_interior", got_at(11), 100);

        run_frame(4, int'($urandom_range(0, 3)), 45, 2, -1, -1);
        repeat (8) run_frame(4, int'($urandom_range(0, 3)), FRAME, 2, -1, -1);

        repeat (4) drive(0, 0, 0, 0);
        check("queue_drained", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
